// File: rtl/axi_mem_responder_pkg.sv
// Shared types and widths for the AXI-subset memory responder.
package axi_mem_responder_pkg;

    localparam int ID_WIDTH  = 4;
    localparam int LEN_WIDTH = 4;
    localparam int LAT_WIDTH = 4;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } write_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_BURST = 2'd2
    } read_state_t;

    // True when a write beat's WLAST disagrees with the beat position in the burst.
    function automatic logic wlast_mismatch(input logic wlast,
                                            input logic [LEN_WIDTH-1:0] cnt,
                                            input logic [LEN_WIDTH-1:0] len);
        return wlast != (cnt == len);
    endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AW/W/B and AR/R channel bundle between the memory arbiter and the responder.
interface axi_mem_responder_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    import axi_mem_responder_pkg::*;

    logic                  awvalid;
    logic                  awready;
    logic [ID_WIDTH-1:0]   awid;
    logic [LEN_WIDTH-1:0]  awlen;
    logic [ADDR_WIDTH-1:0] awaddr;

    logic                  wvalid;
    logic                  wready;
    logic                  wlast;
    logic [ID_WIDTH-1:0]   wid;
    logic [DATA_WIDTH-1:0] wdata;

    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   bid;

    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [LEN_WIDTH-1:0]  arlen;
    logic [ADDR_WIDTH-1:0] araddr;

    logic                  rvalid;
    logic                  rready;
    logic                  rlast;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;

    modport slave (
        input  awvalid, awid, awlen, awaddr,
        output awready,
        input  wvalid, wlast, wid, wdata,
        output wready,
        output bvalid, bid,
        input  bready,
        input  arvalid, arid, arlen, araddr,
        output arready,
        output rvalid, rlast, rid, rdata,
        input  rready
    );

    modport master (
        output awvalid, awid, awlen, awaddr,
        input  awready,
        output wvalid, wlast, wid, wdata,
        input  wready,
        input  bvalid, bid,
        output bready,
        output arvalid, arid, arlen, araddr,
        input  arready,
        input  rvalid, rlast, rid, rdata,
        output rready
    );

endinterface

// File: rtl/axi_rd_channel.sv
// Read channel: AR acceptance, fixed first-beat latency, then one beat per cycle
// out of a registered RDATA, prefetching the next word on every accepted beat.
module axi_rd_channel
    import axi_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_IDX_BITS = 14,
    parameter int READ_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arvalid,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arready,
    input  logic                    rready,
    output logic                    rvalid,
    output logic                    rlast,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [MEM_IDX_BITS-1:0] rd_idx,
    input  logic [DATA_WIDTH-1:0]   rd_data
);

    localparam logic [LAT_WIDTH-1:0]    LAT_LOAD = LAT_WIDTH'(READ_LATENCY - 1);
    localparam logic [LAT_WIDTH-1:0]    LAT_STEP = 4'd1;
    localparam logic [LEN_WIDTH-1:0]    CNT_STEP = 4'd1;
    localparam logic [MEM_IDX_BITS-1:0] IDX_STEP = {{(MEM_IDX_BITS-1){1'b0}}, 1'b1};

    read_state_t             r_state_r, r_state_nxt_s;
    logic [ID_WIDTH-1:0]     r_id_r, r_id_nxt_s;
    logic [LEN_WIDTH-1:0]    r_len_r, r_len_nxt_s;
    logic [LEN_WIDTH-1:0]    r_cnt_r, r_cnt_nxt_s;
    logic [MEM_IDX_BITS-1:0] r_idx_r, r_idx_nxt_s;
    logic [LAT_WIDTH-1:0]    lat_r, lat_nxt_s;
    logic                    arready_r, arready_nxt_s;
    logic                    rvalid_r, rvalid_nxt_s;
    logic                    rlast_r, rlast_nxt_s;
    logic [DATA_WIDTH-1:0]   rdata_r, rdata_nxt_s;
    logic                    unused_addr_s;

    // Byte-offset and above-depth address bits do not select a word.
    assign unused_addr_s = ^{araddr[1:0], araddr[ADDR_WIDTH-1:MEM_IDX_BITS+2]};

    // In a burst the array is looked up one word ahead so an accepted beat can be replaced next cycle.
    always_comb begin
        if (r_state_r == R_BURST) begin
            rd_idx = r_idx_r + IDX_STEP;
        end else begin
            rd_idx = r_idx_r;
        end
    end

    // Next-state and next-output logic of the read FSM.
    always_comb begin
        r_state_nxt_s = r_state_r;
        r_id_nxt_s    = r_id_r;
        r_len_nxt_s   = r_len_r;
        r_cnt_nxt_s   = r_cnt_r;
        r_idx_nxt_s   = r_idx_r;
        lat_nxt_s     = lat_r;
        arready_nxt_s = arready_r;
        rvalid_nxt_s  = rvalid_r;
        rlast_nxt_s   = rlast_r;
        rdata_nxt_s   = rdata_r;
        case (r_state_r)
            R_IDLE: begin
                if (arvalid) begin
                    r_id_nxt_s    = arid;
                    r_len_nxt_s   = arlen;
                    r_idx_nxt_s   = araddr[MEM_IDX_BITS+1:2];
                    r_cnt_nxt_s   = 4'd0;
                    lat_nxt_s     = LAT_LOAD;
                    arready_nxt_s = 1'b0;
                    r_state_nxt_s = R_WAIT;
                end else begin
                    arready_nxt_s = 1'b1;
                end
            end
            R_WAIT: begin
                if (lat_r == 4'd0) begin
                    rdata_nxt_s   = rd_data;
                    rvalid_nxt_s  = 1'b1;
                    rlast_nxt_s   = (r_len_r == 4'd0);
                    r_state_nxt_s = R_BURST;
                end else begin
                    lat_nxt_s = lat_r - LAT_STEP;
                end
            end
            R_BURST: begin
                if (rready) begin
                    if (r_cnt_r == r_len_r) begin
                        rvalid_nxt_s  = 1'b0;
                        rlast_nxt_s   = 1'b0;
                        arready_nxt_s = 1'b1;
                        r_state_nxt_s = R_IDLE;
                    end else begin
                        r_cnt_nxt_s = r_cnt_r + CNT_STEP;
                        r_idx_nxt_s = r_idx_r + IDX_STEP;
                        rdata_nxt_s = rd_data;
                        rlast_nxt_s = ((r_cnt_r + CNT_STEP) == r_len_r);
                    end
                end else begin
                    rvalid_nxt_s = 1'b1;
                end
            end
            default: begin
                arready_nxt_s = 1'b1;
                rvalid_nxt_s  = 1'b0;
                rlast_nxt_s   = 1'b0;
                r_state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            r_id_r    <= 4'd0;
            r_len_r   <= 4'd0;
            r_cnt_r   <= 4'd0;
            r_idx_r   <= {MEM_IDX_BITS{1'b0}};
            lat_r     <= 4'd0;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            r_state_r <= r_state_nxt_s;
            r_id_r    <= r_id_nxt_s;
            r_len_r   <= r_len_nxt_s;
            r_cnt_r   <= r_cnt_nxt_s;
            r_idx_r   <= r_idx_nxt_s;
            lat_r     <= lat_nxt_s;
            arready_r <= arready_nxt_s;
            rvalid_r  <= rvalid_nxt_s;
            rlast_r   <= rlast_nxt_s;
            rdata_r   <= rdata_nxt_s;
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rlast   = rlast_r;
    assign rid     = r_id_r;
    assign rdata   = rdata_r;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI-subset memory endpoint: word array, write channel FSM, sticky protocol error
// flag, and an independent read channel sharing the array through a read port.
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int    ADDR_WIDTH   = 26,
    parameter int    DATA_WIDTH   = 32,
    parameter int    MEM_IDX_BITS = 14,
    parameter int    READ_LATENCY = 4,
    parameter string INIT_FILE    = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_mem_responder_if.slave  bus,
    output logic                proto_err
);

    localparam int                      MEM_DEPTH = 2 ** MEM_IDX_BITS;
    localparam logic [LEN_WIDTH-1:0]    CNT_STEP  = 4'd1;
    localparam logic [MEM_IDX_BITS-1:0] IDX_STEP  = {{(MEM_IDX_BITS-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]   mem_r [MEM_DEPTH];

    write_state_t            w_state_r, w_state_nxt_s;
    logic [ID_WIDTH-1:0]     w_id_r, w_id_nxt_s;
    logic [LEN_WIDTH-1:0]    w_len_r, w_len_nxt_s;
    logic [LEN_WIDTH-1:0]    w_cnt_r, w_cnt_nxt_s;
    logic [MEM_IDX_BITS-1:0] w_idx_r, w_idx_nxt_s;
    logic                    awready_r, awready_nxt_s;
    logic                    wready_r, wready_nxt_s;
    logic                    bvalid_r, bvalid_nxt_s;
    logic [ID_WIDTH-1:0]     bid_r, bid_nxt_s;
    logic                    proto_err_r, proto_err_nxt_s;
    logic                    mem_we_s;

    logic [MEM_IDX_BITS-1:0] rd_idx_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;
    logic                    arready_s, rvalid_s, rlast_s;
    logic [ID_WIDTH-1:0]     rid_s;
    logic [DATA_WIDTH-1:0]   rdata_s;
    logic                    unused_addr_s;

    // Byte-offset and above-depth address bits do not select a word.
    assign unused_addr_s = ^{bus.awaddr[1:0], bus.awaddr[ADDR_WIDTH-1:MEM_IDX_BITS+2]};

    assign mem_we_s  = (w_state_r == W_DATA) && bus.wvalid;
    assign rd_data_s = mem_r[rd_idx_s];

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[w_idx_r] <= bus.wdata;
        end
    end

    // Next-state and next-output logic of the write FSM, including protocol checks.
    always_comb begin
        w_state_nxt_s   = w_state_r;
        w_id_nxt_s      = w_id_r;
        w_len_nxt_s     = w_len_r;
        w_cnt_nxt_s     = w_cnt_r;
        w_idx_nxt_s     = w_idx_r;
        awready_nxt_s   = awready_r;
        wready_nxt_s    = wready_r;
        bvalid_nxt_s    = bvalid_r;
        bid_nxt_s       = bid_r;
        proto_err_nxt_s = proto_err_r;
        case (w_state_r)
            W_IDLE: begin
                if (bus.awvalid) begin
                    w_id_nxt_s    = bus.awid;
                    w_len_nxt_s   = bus.awlen;
                    w_idx_nxt_s   = bus.awaddr[MEM_IDX_BITS+1:2];
                    w_cnt_nxt_s   = 4'd0;
                    awready_nxt_s = 1'b0;
                    wready_nxt_s  = 1'b1;
                    w_state_nxt_s = W_DATA;
                end else begin
                    awready_nxt_s = 1'b1;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    if ((bus.wid != w_id_r) || wlast_mismatch(bus.wlast, w_cnt_r, w_len_r)) begin
                        proto_err_nxt_s = 1'b1;
                    end else begin
                        proto_err_nxt_s = proto_err_r;
                    end
                    // Once LEN is reached the index and count freeze, so stray beats overwrite the last word.
                    if (w_cnt_r != w_len_r) begin
                        w_cnt_nxt_s = w_cnt_r + CNT_STEP;
                        w_idx_nxt_s = w_idx_r + IDX_STEP;
                    end else begin
                        w_cnt_nxt_s = w_cnt_r;
                        w_idx_nxt_s = w_idx_r;
                    end
                    if (bus.wlast) begin
                        wready_nxt_s  = 1'b0;
                        bvalid_nxt_s  = 1'b1;
                        bid_nxt_s     = w_id_r;
                        w_state_nxt_s = W_RESP;
                    end else begin
                        wready_nxt_s = 1'b1;
                    end
                end else begin
                    wready_nxt_s = 1'b1;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    bvalid_nxt_s  = 1'b0;
                    awready_nxt_s = 1'b1;
                    w_state_nxt_s = W_IDLE;
                end else begin
                    bvalid_nxt_s = 1'b1;
                end
            end
            default: begin
                awready_nxt_s = 1'b1;
                wready_nxt_s  = 1'b0;
                bvalid_nxt_s  = 1'b0;
                w_state_nxt_s = W_IDLE;
            end
        endcase
    end

    // Write FSM state, registered outputs and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r   <= W_IDLE;
            w_id_r      <= 4'd0;
            w_len_r     <= 4'd0;
            w_cnt_r     <= 4'd0;
            w_idx_r     <= {MEM_IDX_BITS{1'b0}};
            awready_r   <= 1'b1;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bid_r       <= 4'd0;
            proto_err_r <= 1'b0;
        end else begin
            w_state_r   <= w_state_nxt_s;
            w_id_r      <= w_id_nxt_s;
            w_len_r     <= w_len_nxt_s;
            w_cnt_r     <= w_cnt_nxt_s;
            w_idx_r     <= w_idx_nxt_s;
            awready_r   <= awready_nxt_s;
            wready_r    <= wready_nxt_s;
            bvalid_r    <= bvalid_nxt_s;
            bid_r       <= bid_nxt_s;
            proto_err_r <= proto_err_nxt_s;
        end
    end

    assign bus.awready = awready_r;
    assign bus.wready  = wready_r;
    assign bus.bvalid  = bvalid_r;
    assign bus.bid     = bid_r;
    assign proto_err   = proto_err_r;

    axi_rd_channel #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .MEM_IDX_BITS (MEM_IDX_BITS),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd (
        .clk     (clk),
        .rst_n   (rst_n),
        .arvalid (bus.arvalid),
        .arid    (bus.arid),
        .arlen   (bus.arlen),
        .araddr  (bus.araddr),
        .arready (arready_s),
        .rready  (bus.rready),
        .rvalid  (rvalid_s),
        .rlast   (rlast_s),
        .rid     (rid_s),
        .rdata   (rdata_s),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s)
    );

    assign bus.arready = arready_s;
    assign bus.rvalid  = rvalid_s;
    assign bus.rlast   = rlast_s;
    assign bus.rid     = rid_s;
    assign bus.rdata   = rdata_s;

endmodule
